// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared state encoding and constants for the instruction memory controller
package imem_ctrl_pkg;
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;
  localparam logic [31:0] FAULT_DATA = 32'h0;
endpackage

// File: rtl/imem_load_counter.sv
// imem_load_counter: saturating loader byte counter with clear, increment and last-address flag
module imem_load_counter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W:0]   cnt_o,
  output logic              at_end_o
);
  logic [ADDR_W:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && !cnt_q[ADDR_W]) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  assign cnt_o    = cnt_q;
  assign at_end_o = cnt_q == {1'b0, {ADDR_W{1'b1}}};
endmodule

// File: rtl/imem_controller.sv
// imem_controller: arbitrates the instruction memory port between boot loader and CPU fetch
module imem_controller
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 10,
  parameter bit BOOT_LOAD   = 1'b1
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_ld_start,
  input  logic              I_ld_valid,
  input  logic [7:0]        I_ld_data,
  input  logic              I_ld_last,
  output logic              O_ld_ready,
  input  logic              I_fetch_req,
  input  logic [31:0]       I_fetch_addr,
  output logic              O_fetch_ready,
  output logic              O_fetch_valid,
  output logic [31:0]       O_fetch_data,
  output logic              O_fetch_fault,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic              O_mem_we,
  output logic [7:0]        O_mem_wdata,
  input  logic [31:0]       I_mem_rdata,
  output logic              O_cpu_hold,
  output logic [ADDR_W:0]   O_load_count
);
  state_e state_q, state_d;
  logic valid_q, valid_d, fault_q, fault_d;
  logic [31:0] data_q, data_d;
  logic ld_acc, fetch_acc, flt, at_end, cnt_clr;
  logic [ADDR_W:0] cnt;
  imem_load_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk_i(I_clk), .rst_ni(I_rst_n), .clr_i(cnt_clr), .inc_i(ld_acc),
    .cnt_o(cnt), .at_end_o(at_end)
  );
  // Strobes are gated by reset so nothing reaches the array while it is held.
  always_comb begin
    O_ld_ready    = I_rst_n && state_q == LOAD;
    O_fetch_ready = I_rst_n && state_q == RUN && !I_ld_start;
    ld_acc        = O_ld_ready && I_ld_valid;
    fetch_acc     = O_fetch_ready && I_fetch_req;
    cnt_clr       = I_rst_n && state_q == RUN && I_ld_start;
    flt           = I_fetch_addr[1:0] != 2'b0 || I_fetch_addr > 32'(DEPTH_BYTES - 4);
    state_d       = cnt_clr ? LOAD : (ld_acc && (I_ld_last || at_end)) ? RUN : state_q;
    valid_d       = fetch_acc;
    fault_d       = fetch_acc && flt;
    data_d        = (fetch_acc && !flt) ? I_mem_rdata : FAULT_DATA;
    O_mem_we      = ld_acc;
    O_mem_wdata   = ld_acc ? I_ld_data : 8'h0;
    O_mem_addr    = ld_acc ? cnt[ADDR_W-1:0] : fetch_acc ? I_fetch_addr[ADDR_W-1:0] : '0;
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      state_q <= BOOT_LOAD ? LOAD : RUN;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      data_q  <= data_d;
    end
  assign O_fetch_valid = valid_q;
  assign O_fetch_fault = fault_q;
  assign O_fetch_data  = data_q;
  assign O_cpu_hold    = state_q == LOAD;
  assign O_load_count  = cnt;
endmodule

// File: tb/tb_imem_controller.sv
// tb_imem_controller: directed checks of load, fetch, fault, priority and reset behaviour
module tb_imem_controller;
  logic        I_clk = 1'b0, I_rst_n = 1'b0;
  logic        I_ld_start = 1'b0, I_ld_valid = 1'b0, I_ld_last = 1'b0, I_fetch_req = 1'b0;
  logic [7:0]  I_ld_data = 8'h0;
  logic [31:0] I_fetch_addr = 32'h0, I_mem_rdata;
  logic        O_ld_ready, O_fetch_ready, O_fetch_valid, O_fetch_fault, O_mem_we, O_cpu_hold;
  logic [31:0] O_fetch_data;
  logic [9:0]  O_mem_addr;
  logic [7:0]  O_mem_wdata;
  logic [10:0] O_load_count;
  logic [7:0]  mem [1024];
  int n_chk = 0, n_pass = 0;
  always #5 I_clk = ~I_clk;
  imem_controller dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ld_start(I_ld_start), .I_ld_valid(I_ld_valid),
    .I_ld_data(I_ld_data), .I_ld_last(I_ld_last), .O_ld_ready(O_ld_ready),
    .I_fetch_req(I_fetch_req), .I_fetch_addr(I_fetch_addr), .O_fetch_ready(O_fetch_ready),
    .O_fetch_valid(O_fetch_valid), .O_fetch_data(O_fetch_data), .O_fetch_fault(O_fetch_fault),
    .O_mem_addr(O_mem_addr), .O_mem_we(O_mem_we), .O_mem_wdata(O_mem_wdata),
    .I_mem_rdata(I_mem_rdata), .O_cpu_hold(O_cpu_hold), .O_load_count(O_load_count)
  );
  always @(posedge I_clk) if (O_mem_we) mem[O_mem_addr] <= O_mem_wdata;
  assign I_mem_rdata = {mem[O_mem_addr + 10'd3], mem[O_mem_addr + 10'd2],
                        mem[O_mem_addr + 10'd1], mem[O_mem_addr]};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge I_clk); #1;
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    I_ld_valid = 1'b1; I_ld_data = d; I_ld_last = last;
    tick();
    I_ld_valid = 1'b0; I_ld_last = 1'b0;
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_f, input string tag);
    I_fetch_req = 1'b1; I_fetch_addr = a;
    tick();
    I_fetch_req = 1'b0;
    check({tag, "_valid"}, O_fetch_valid, 1);
    check({tag, "_data"}, O_fetch_data, exp_d);
    check({tag, "_fault"}, O_fetch_fault, exp_f);
  endtask
  localparam logic [7:0] PROG [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  initial begin
    I_ld_valid = 1'b1; I_ld_data = 8'hEE;
    #12;
    check("rst_hold", O_cpu_hold, 1);
    check("rst_count", O_load_count, 0);
    check("rst_we", O_mem_we, 0);
    check("rst_addr", O_mem_addr, 0);
    check("rst_valid", O_fetch_valid, 0);
    I_ld_valid = 1'b0;
    tick();
    I_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      I_ld_valid = 1'b1; I_ld_data = PROG[i]; I_ld_last = (i == 7);
      #1;
      check("ld_we", O_mem_we, 1);
      check("ld_addr", O_mem_addr, i);
      check("ld_wdata", O_mem_wdata, PROG[i]);
      tick();
    end
    I_ld_valid = 1'b0; I_ld_last = 1'b0;
    #1;
    check("boot_hold", O_cpu_hold, 0);
    check("boot_count", O_load_count, 8);
    check("boot_fready", O_fetch_ready, 1);
    check("boot_ldready", O_ld_ready, 0);
    I_fetch_req = 1'b1; I_fetch_addr = 32'h0;
    #1;
    check("f0_addr", O_mem_addr, 0);
    tick();
    check("f0_valid", O_fetch_valid, 1);
    check("f0_data", O_fetch_data, 32'h00000013);
    check("f0_fault", O_fetch_fault, 0);
    I_fetch_addr = 32'h4;
    tick();
    check("f4_valid", O_fetch_valid, 1);
    check("f4_data", O_fetch_data, 32'h00100093);
    check("f4_fault", O_fetch_fault, 0);
    I_fetch_req = 1'b0;
    fetch(32'h2, 32'h0, 1'b1, "mis2");
    fetch(32'h3FD, 32'h0, 1'b1, "range3fd");
    fetch(32'h400, 32'h0, 1'b1, "range400");
    tick();
    check("idle_valid", O_fetch_valid, 0);
    check("idle_addr", O_mem_addr, 0);
    I_fetch_req = 1'b1; I_fetch_addr = 32'h4;
    tick();
    I_ld_start = 1'b1; I_fetch_addr = 32'h8;
    #1;
    check("pri_fready", O_fetch_ready, 0);
    check("pri_addr", O_mem_addr, 0);
    check("pri_inflight_valid", O_fetch_valid, 1);
    check("pri_inflight_data", O_fetch_data, 32'h00100093);
    tick();
    I_ld_start = 1'b0; I_fetch_req = 1'b0;
    check("pri_hold", O_cpu_hold, 1);
    check("pri_count", O_load_count, 0);
    check("pri_novalid", O_fetch_valid, 0);
    for (int i = 0; i < 1024; i++) send(8'(i), 1'b0);
    check("full_hold", O_cpu_hold, 0);
    check("full_count", O_load_count, 1024);
    I_ld_valid = 1'b1; I_ld_data = 8'h77;
    #1;
    check("full_ldready", O_ld_ready, 0);
    check("full_we", O_mem_we, 0);
    tick();
    I_ld_valid = 1'b0;
    check("full_count2", O_load_count, 1024);
    fetch(32'h3FC, 32'hFFFEFDFC, 1'b0, "top3fc");
    fetch(32'h100, 32'h03020100, 1'b0, "mid100");
    I_ld_start = 1'b1;
    tick();
    I_ld_start = 1'b0;
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), 1'b0);
    check("mid_count", O_load_count, 5);
    I_ld_valid = 1'b1; I_ld_data = 8'hCC;
    #2;
    I_rst_n = 1'b0;
    #1;
    check("arst_count", O_load_count, 0);
    check("arst_we", O_mem_we, 0);
    check("arst_addr", O_mem_addr, 0);
    check("arst_hold", O_cpu_hold, 1);
    I_ld_valid = 1'b0;
    tick();
    I_rst_n = 1'b1;
    I_ld_valid = 1'b1; I_ld_data = 8'h5A; I_ld_last = 1'b1;
    #1;
    check("post_addr", O_mem_addr, 0);
    check("post_we", O_mem_we, 1);
    tick();
    I_ld_valid = 1'b0; I_ld_last = 1'b0;
    check("post_count", O_load_count, 1);
    check("post_hold", O_cpu_hold, 0);
    fetch(32'h0, 32'hA3A2A15A, 1'b0, "post_f0");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
